// File: rtl/icache_stage1_assoc.sv
// ICache stage 1: indexes WAYS tag/data arrays for each accepted fetch, keeps per-set age
// counters for victim selection, writes MSHR refills and runs the invalidate-all sweep.
module icache_stage1_assoc #(
  parameter int WAYS      = 4,
  parameter int SETS      = 64,
  parameter int LINE_BITS = 512,
  parameter int TAG_BITS  = 20,
  parameter int AGE_BITS  = 3,
  parameter int ADDR_BITS = 32,
  localparam int OFS      = $clog2(LINE_BITS / 8),
  localparam int IDX      = $clog2(SETS)
) (
  input  logic                      Clk,
  input  logic                      Rest,
  input  logic                      IcacheStop,
  input  logic                      IcacheFlash,
  input  logic                      FetchAble,
  input  logic [ADDR_BITS-1:0]      FetchPc,
  output logic                      FetchReady,
  output logic                      ToStage2Able,
  output logic [ADDR_BITS-1:0]      ToStage2Pc,
  output logic [WAYS*LINE_BITS-1:0] To2Date,
  output logic [WAYS*TAG_BITS-1:0]  To2Tag,
  output logic [WAYS-1:0]           To2Valid,
  input  logic                      InHitAble,
  input  logic [IDX-1:0]            InHitIndex,
  input  logic [WAYS-1:0]           InHitWay,
  input  logic                      InNewAble,
  input  logic [IDX-1:0]            InNewIndex,
  input  logic [TAG_BITS-1:0]       InNewTag,
  input  logic [LINE_BITS-1:0]      InNewDate,
  output logic [WAYS-1:0]           RefillWay,
  input  logic                      InvAll,
  output logic                      InvBusy
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;
  logic [IDX-1:0] sweep_cnt_q, sweep_cnt_d;

  logic [LINE_BITS-1:0] data_mem [WAYS][SETS];
  logic [TAG_BITS-1:0]  tag_mem  [WAYS][SETS];
  logic                 valid_q  [SETS][WAYS];
  logic [AGE_BITS-1:0]  age_q    [SETS][WAYS];

  logic [IDX-1:0] fetch_idx;
  logic           accept, refill_en, hit_en;

  function automatic logic [AGE_BITS-1:0] sat_inc(input logic [AGE_BITS-1:0] a);
    sat_inc = (a == '1) ? a : a + 1'b1;
  endfunction

  assign fetch_idx  = FetchPc[OFS+IDX-1:OFS];
  assign FetchReady = ~IcacheStop & ~InNewAble & (state_q == IDLE);
  assign accept     = FetchAble & FetchReady;
  assign refill_en  = InNewAble & ~IcacheStop & (state_q == IDLE);
  // A refill to the hit set owns that set's ages this cycle.
  assign hit_en     = InHitAble & ~IcacheStop & ~(refill_en & (InHitIndex == InNewIndex));
  assign InvBusy    = (state_q == SWEEP);

  // Victim: lowest invalid way, else oldest way with ties to the lowest index.
  always_comb begin
    logic                found;
    logic [WAY_W-1:0]    best_way;
    logic [AGE_BITS-1:0] best_age;
    found     = 1'b0;
    best_way  = '0;
    best_age  = age_q[InNewIndex][0];
    RefillWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[InNewIndex][w] && !found) begin
        found    = 1'b1;
        best_way = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[InNewIndex][w] > best_age) begin
          best_age = age_q[InNewIndex][w];
          best_way = WAY_W'(w);
        end
      end
    end
    RefillWay[best_way] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      IDLE: begin
        if (InvAll && !InNewAble) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end
      end
      SWEEP: begin
        if (!IcacheStop) begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == IDX'(SETS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_q     <= IDLE;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Later assignments win: the sweep clear is last, though it never overlaps a refill.
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= '0;
        end
      end
    end else begin
      if (hit_en) begin
        for (int w = 0; w < WAYS; w++)
          age_q[InHitIndex][w] <= InHitWay[w] ? '0 : sat_inc(age_q[InHitIndex][w]);
      end
      if (refill_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (RefillWay[w]) begin
            valid_q[InNewIndex][w] <= 1'b1;
            age_q[InNewIndex][w]   <= '0;
          end else begin
            age_q[InNewIndex][w]   <= sat_inc(age_q[InNewIndex][w]);
          end
        end
      end
      if (state_q == SWEEP && !IcacheStop) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[sweep_cnt_q][w] <= 1'b0;
          age_q[sweep_cnt_q][w]   <= '0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (refill_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (RefillWay[w]) begin
          data_mem[w][InNewIndex] <= InNewDate;
          tag_mem[w][InNewIndex]  <= InNewTag;
        end
      end
    end
  end

  // Arrays are read only on acceptance, so a stall holds the captured line untouched.
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      ToStage2Able <= 1'b0;
      ToStage2Pc   <= '0;
      To2Date      <= '0;
      To2Tag       <= '0;
      To2Valid     <= '0;
    end else if (!IcacheStop) begin
      if (IcacheFlash) begin
        ToStage2Able <= 1'b0;
        ToStage2Pc   <= '0;
      end else if (accept) begin
        ToStage2Able <= 1'b1;
        ToStage2Pc   <= FetchPc;
        for (int w = 0; w < WAYS; w++) begin
          To2Date[w*LINE_BITS +: LINE_BITS] <= data_mem[w][fetch_idx];
          To2Tag[w*TAG_BITS +: TAG_BITS]    <= tag_mem[w][fetch_idx];
          To2Valid[w]                       <= valid_q[fetch_idx][w];
        end
      end else begin
        ToStage2Able <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_stage1_assoc.sv
// Directed bench for icache_stage1_assoc at its default parameters (4 ways, 64 sets, 512-bit lines).
module tb_icache_stage1_assoc;
  localparam int WAYS = 4, SETS = 64, LB = 512, TB = 20, AB = 3, PA = 32;

  logic              Clk, Rest, IcacheStop, IcacheFlash, FetchAble;
  logic [PA-1:0]     FetchPc;
  logic              FetchReady, ToStage2Able;
  logic [PA-1:0]     ToStage2Pc;
  logic [WAYS*LB-1:0] To2Date;
  logic [WAYS*TB-1:0] To2Tag;
  logic [WAYS-1:0]   To2Valid;
  logic              InHitAble;
  logic [5:0]        InHitIndex;
  logic [WAYS-1:0]   InHitWay;
  logic              InNewAble;
  logic [5:0]        InNewIndex;
  logic [TB-1:0]     InNewTag;
  logic [LB-1:0]     InNewDate;
  logic [WAYS-1:0]   RefillWay;
  logic              InvAll, InvBusy;

  int checks = 0;
  int errors = 0;

  icache_stage1_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB), .TAG_BITS(TB),
                        .AGE_BITS(AB), .ADDR_BITS(PA)) dut (
    .Clk(Clk), .Rest(Rest), .IcacheStop(IcacheStop), .IcacheFlash(IcacheFlash),
    .FetchAble(FetchAble), .FetchPc(FetchPc), .FetchReady(FetchReady),
    .ToStage2Able(ToStage2Able), .ToStage2Pc(ToStage2Pc), .To2Date(To2Date),
    .To2Tag(To2Tag), .To2Valid(To2Valid), .InHitAble(InHitAble), .InHitIndex(InHitIndex),
    .InHitWay(InHitWay), .InNewAble(InNewAble), .InNewIndex(InNewIndex), .InNewTag(InNewTag),
    .InNewDate(InNewDate), .RefillWay(RefillWay), .InvAll(InvAll), .InvBusy(InvBusy)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [LB-1:0] mk_line(input logic [31:0] s);
    mk_line = {16{s}};
  endfunction

  function automatic logic [PA-1:0] pc_of(input int idx, input logic [5:0] ofs);
    pc_of = PA'(32'h0004_0000 | (idx << 6) | int'(ofs));
  endfunction

  // driver tasks
  task automatic idle_inputs();
    IcacheStop = 0; IcacheFlash = 0; FetchAble = 0; FetchPc = '0;
    InHitAble = 0; InHitIndex = '0; InHitWay = '0;
    InNewAble = 0; InNewIndex = '0; InNewTag = '0; InNewDate = '0; InvAll = 0;
  endtask

  task automatic do_refill(input int idx, input logic [TB-1:0] tag, input logic [31:0] seed);
    InNewAble = 1; InNewIndex = 6'(idx); InNewTag = tag; InNewDate = mk_line(seed);
    step();
    InNewAble = 0;
  endtask

  task automatic do_hit(input int idx, input logic [WAYS-1:0] way);
    InHitAble = 1; InHitIndex = 6'(idx); InHitWay = way;
    step();
    InHitAble = 0;
  endtask

  task automatic do_fetch(input logic [PA-1:0] pc);
    FetchAble = 1; FetchPc = pc;
    step();
    FetchAble = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rest = 0;
    step(); step();
    checks++; if (ToStage2Able !== 1'b0) begin errors++; $display("FAIL reset_able got %b exp 0", ToStage2Able); end
    checks++; if (ToStage2Pc !== '0) begin errors++; $display("FAIL reset_pc got %h exp 0", ToStage2Pc); end
    checks++; if (To2Valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", To2Valid); end
    checks++; if (To2Tag !== '0) begin errors++; $display("FAIL reset_tag got %h exp 0", To2Tag); end
    checks++; if (To2Date !== '0) begin errors++; $display("FAIL reset_date got nonzero exp 0"); end
    checks++; if (InvBusy !== 1'b0) begin errors++; $display("FAIL reset_invbusy got %b exp 0", InvBusy); end
    Rest = 1;
    step();
    checks++; if (FetchReady !== 1'b1) begin errors++; $display("FAIL reset_fetchready got %b exp 1", FetchReady); end
  endtask

  task automatic test_refill();
    logic [WAYS-1:0] exp_way;
    for (int w = 0; w < WAYS; w++) begin
      InNewAble = 1; InNewIndex = 6'd5; InNewTag = TB'(32'h50 + w); InNewDate = mk_line(32'h5500_0000 + w);
      #1;
      exp_way = 4'b0001 << w;
      checks++; if (RefillWay !== exp_way) begin errors++; $display("FAIL refill_way%0d got %b exp %b", w, RefillWay, exp_way); end
      checks++; if (FetchReady !== 1'b0) begin errors++; $display("FAIL refill_fetchready got %b exp 0", FetchReady); end
      step();
    end
    InNewAble = 0;
    do_fetch(pc_of(5, 6'h04));
    checks++; if (ToStage2Able !== 1'b1) begin errors++; $display("FAIL fetch5_able got %b exp 1", ToStage2Able); end
    checks++; if (ToStage2Pc !== pc_of(5, 6'h04)) begin errors++; $display("FAIL fetch5_pc got %h exp %h", ToStage2Pc, pc_of(5, 6'h04)); end
    checks++; if (To2Valid !== 4'b1111) begin errors++; $display("FAIL fetch5_valid got %b exp 1111", To2Valid); end
    for (int w = 0; w < WAYS; w++) begin
      checks++; if (To2Tag[w*TB +: TB] !== TB'(32'h50 + w)) begin errors++; $display("FAIL fetch5_tag%0d got %h exp %h", w, To2Tag[w*TB +: TB], 32'h50 + w); end
      checks++; if (To2Date[w*LB +: LB] !== mk_line(32'h5500_0000 + w)) begin errors++; $display("FAIL fetch5_date%0d got %h exp %h", w, To2Date[w*LB +: 32], 32'h5500_0000 + w); end
    end
    step();
    checks++; if (ToStage2Able !== 1'b0) begin errors++; $display("FAIL fetch5_bubble got %b exp 0", ToStage2Able); end
  endtask

  task automatic test_victim();
    // ages after fills are {3,2,1,0}; hits on 0,2,3 leave way 1 oldest
    do_hit(5, 4'b0001); do_hit(5, 4'b0100); do_hit(5, 4'b1000);
    InNewIndex = 6'd5; #1;
    checks++; if (RefillWay !== 4'b0010) begin errors++; $display("FAIL victim_after_hits got %b exp 0010", RefillWay); end
    for (int i = 0; i < 8; i++) do_hit(5, 4'b0001);
    InNewIndex = 6'd5; #1;
    checks++; if (RefillWay !== 4'b0010) begin errors++; $display("FAIL victim_saturated_tie got %b exp 0010", RefillWay); end
    do_hit(5, 4'b0010);
    InNewIndex = 6'd5; #1;
    checks++; if (RefillWay !== 4'b0100) begin errors++; $display("FAIL victim_tie_next got %b exp 0100", RefillWay); end
  endtask

  task automatic test_stall_flush();
    do_fetch(pc_of(5, 6'h08));
    IcacheStop = 1; FetchAble = 1; FetchPc = pc_of(9, 6'h00);
    InNewAble = 1; InNewIndex = 6'd20; InNewTag = 'h2; InNewDate = mk_line(32'h2020_2020);
    for (int i = 0; i < 3; i++) begin
      IcacheFlash = (i == 2);
      step();
      checks++; if (ToStage2Able !== 1'b1) begin errors++; $display("FAIL stall_able c%0d got %b exp 1", i, ToStage2Able); end
      checks++; if (ToStage2Pc !== pc_of(5, 6'h08)) begin errors++; $display("FAIL stall_pc c%0d got %h exp %h", i, ToStage2Pc, pc_of(5, 6'h08)); end
      checks++; if (To2Date[2*LB +: LB] !== mk_line(32'h5500_0002)) begin errors++; $display("FAIL stall_date c%0d got %h exp 55000002", i, To2Date[2*LB +: 32]); end
      checks++; if (FetchReady !== 1'b0) begin errors++; $display("FAIL stall_fetchready c%0d got %b exp 0", i, FetchReady); end
    end
    InNewAble = 0; IcacheStop = 0; FetchAble = 0; IcacheFlash = 1;
    step();
    IcacheFlash = 0;
    checks++; if (ToStage2Able !== 1'b0) begin errors++; $display("FAIL flush_able got %b exp 0", ToStage2Able); end
    checks++; if (ToStage2Pc !== '0) begin errors++; $display("FAIL flush_pc got %h exp 0", ToStage2Pc); end
    InNewIndex = 6'd20; #1;
    checks++; if (RefillWay !== 4'b0001) begin errors++; $display("FAIL stalled_refill_ignored got %b exp 0001", RefillWay); end
  endtask

  task automatic test_collision();
    for (int w = 0; w < WAYS; w++) do_refill(9, TB'(32'h90 + w), 32'h9900_0000 + w);
    // ages {3,2,1,0}: refill goes to way 0 while a hit targets way 1
    InNewAble = 1; InNewIndex = 6'd9; InNewTag = 'h9f; InNewDate = mk_line(32'h9999_ffff);
    InHitAble = 1; InHitIndex = 6'd9; InHitWay = 4'b0010;
    #1;
    checks++; if (RefillWay !== 4'b0001) begin errors++; $display("FAIL collide_way got %b exp 0001", RefillWay); end
    checks++; if (FetchReady !== 1'b0) begin errors++; $display("FAIL collide_fetchready got %b exp 0", FetchReady); end
    step();
    InNewAble = 0; InHitAble = 0;
    InNewIndex = 6'd9; #1;
    checks++; if (RefillWay !== 4'b0010) begin errors++; $display("FAIL collide_next_victim got %b exp 0010", RefillWay); end
    do_fetch(pc_of(9, 6'h10));
    checks++; if (To2Tag[0 +: TB] !== TB'(32'h9f)) begin errors++; $display("FAIL collide_tag0 got %h exp 9f", To2Tag[0 +: TB]); end
    checks++; if (To2Date[0 +: LB] !== mk_line(32'h9999_ffff)) begin errors++; $display("FAIL collide_date0 got %h exp 9999ffff", To2Date[0 +: 32]); end
  endtask

  task automatic test_back_to_back();
    logic [PA-1:0] pcs [3];
    logic [WAYS-1:0] vals [3];
    pcs[0] = pc_of(5, 6'h00); pcs[1] = pc_of(9, 6'h3c); pcs[2] = pc_of(7, 6'h20);
    vals[0] = 4'b1111; vals[1] = 4'b1111; vals[2] = 4'b0000;
    FetchAble = 1;
    for (int i = 0; i < 3; i++) begin
      FetchPc = pcs[i];
      step();
      checks++; if (ToStage2Able !== 1'b1 || ToStage2Pc !== pcs[i]) begin errors++; $display("FAIL b2b_pc%0d got %b/%h exp 1/%h", i, ToStage2Able, ToStage2Pc, pcs[i]); end
      checks++; if (To2Valid !== vals[i]) begin errors++; $display("FAIL b2b_valid%0d got %b exp %b", i, To2Valid, vals[i]); end
    end
    FetchAble = 0;
    step();
  endtask

  task automatic test_sweep();
    int n;
    InvAll = 1; step(); InvAll = 0;
    FetchAble = 1; FetchPc = pc_of(5, 6'h00);
    n = 0;
    while (InvBusy && n < 200) begin
      n++;
      step();
      if (n == 3) begin
        checks++; if (ToStage2Able !== 1'b0 || FetchReady !== 1'b0) begin errors++; $display("FAIL sweep_blocks_fetch got able %b ready %b exp 0 0", ToStage2Able, FetchReady); end
      end
    end
    checks++; if (n !== SETS) begin errors++; $display("FAIL sweep_length got %0d exp %0d", n, SETS); end
    checks++; if (FetchReady !== 1'b1) begin errors++; $display("FAIL sweep_ready_after got %b exp 1", FetchReady); end
    step();
    checks++; if (ToStage2Able !== 1'b1 || To2Valid !== 4'b0000) begin errors++; $display("FAIL sweep_set5_valid got %b/%b exp 1/0000", ToStage2Able, To2Valid); end
    FetchPc = pc_of(9, 6'h00);
    step();
    FetchAble = 0;
    checks++; if (To2Valid !== 4'b0000) begin errors++; $display("FAIL sweep_set9_valid got %b exp 0000", To2Valid); end

    // stalled sweep
    do_refill(5, 'h77, 32'h7777_7777);
    InvAll = 1; step(); InvAll = 0;
    n = 0;
    while (InvBusy && n < 200) begin
      n++;
      IcacheStop = (n >= 10 && n < 13);
      step();
    end
    IcacheStop = 0;
    checks++; if (n !== SETS + 3) begin errors++; $display("FAIL sweep_stalled_length got %0d exp %0d", n, SETS + 3); end

    // reset mid-sweep
    do_refill(40, 'h40, 32'h4040_4040);
    InvAll = 1; step(); InvAll = 0;
    for (int i = 0; i < 29; i++) step();
    checks++; if (InvBusy !== 1'b1) begin errors++; $display("FAIL sweep_mid_busy got %b exp 1", InvBusy); end
    Rest = 0; step(); Rest = 1;
    checks++; if (InvBusy !== 1'b0) begin errors++; $display("FAIL sweep_reset_busy got %b exp 0", InvBusy); end
    InNewIndex = 6'd40; #1;
    checks++; if (RefillWay !== 4'b0001) begin errors++; $display("FAIL sweep_reset_victim got %b exp 0001", RefillWay); end
    do_fetch(pc_of(40, 6'h00));
    checks++; if (ToStage2Able !== 1'b1 || To2Valid !== 4'b0000) begin errors++; $display("FAIL sweep_reset_valid got %b/%b exp 1/0000", ToStage2Able, To2Valid); end
  endtask

  initial begin
    Rest = 0;
    idle_inputs();
    test_reset();
    test_refill();
    test_victim();
    test_stall_flush();
    test_collision();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
